// File: rtl/bb_arbiter.sv
// bb_arbiter: round-robin N:1 Blackbone arbiter with registered one-hot grant, optional hold limit and read-data return.
module bb_arbiter #(
    parameter int MASTERS    = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_HOLD   = 0
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [MASTERS-1:0][ADDR_WIDTH-1:0]   m_addr_i,
    input  logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_din_i,
    input  logic [MASTERS-1:0]                   m_en_i,
    input  logic [MASTERS-1:0]                   m_we_i,
    output logic [MASTERS-1:0]                   m_gnt_o,
    output logic [MASTERS-1:0][DATA_WIDTH-1:0]   m_dout_o,
    output logic [MASTERS-1:0]                   m_rvalid_o,
    output logic [ADDR_WIDTH-1:0]                s_addr_o,
    output logic [DATA_WIDTH-1:0]                s_din_o,
    output logic                                 s_en_o,
    output logic                                 s_we_o,
    input  logic [DATA_WIDTH-1:0]                s_dout_i
);
    localparam int PW = $clog2(MASTERS);
    localparam int HW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

    logic [MASTERS-1:0] gnt_q, gnt_d, rvalid_q, rvalid_d;
    logic [PW-1:0]      last_q, last_d;
    logic [HW-1:0]      hold_q, hold_d;
    logic               own_en, preempt, rearb;
    logic [PW:0]        pick;

    // Returns {found, index} of the first requester after ptr, wrapping modulo MASTERS.
    function automatic logic [PW:0] rr_pick(input logic [MASTERS-1:0] req, input logic [PW-1:0] ptr);
        logic [PW:0] r;
        logic [PW:0] idx;
        r = '0;
        for (int k = MASTERS; k >= 1; k--) begin
            idx = {1'b0, ptr} + (PW+1)'(k);
            if (idx >= (PW+1)'(MASTERS)) idx = idx - (PW+1)'(MASTERS);
            if (req[idx[PW-1:0]]) r = {1'b1, idx[PW-1:0]};
        end
        return r;
    endfunction

    always_comb begin
        own_en   = |(gnt_q & m_en_i);
        preempt  = (MAX_HOLD > 0) && own_en && (int'(hold_q) >= MAX_HOLD - 1) && |(m_en_i & ~gnt_q);
        rearb    = !own_en || preempt;
        pick     = rr_pick(own_en ? (m_en_i & ~gnt_q) : m_en_i, last_q);
        gnt_d    = rearb ? (pick[PW] ? (MASTERS'(1) << pick[PW-1:0]) : '0) : gnt_q;
        last_d   = (rearb && pick[PW]) ? pick[PW-1:0] : last_q;
        hold_d   = rearb ? '0 : ((int'(hold_q) < MAX_HOLD) ? hold_q + 1'b1 : hold_q);
        rvalid_d = gnt_q & m_en_i & ~m_we_i;
    end

    // Grant is one-hot, so a plain priority mux over the owner is enough.
    always_comb begin
        s_addr_o = '0;
        s_din_o  = '0;
        s_we_o   = 1'b0;
        s_en_o   = own_en;
        for (int i = 0; i < MASTERS; i++) begin
            if (gnt_q[i]) begin
                s_addr_o = m_addr_i[i];
                s_din_o  = m_din_i[i];
                s_we_o   = m_we_i[i];
            end
            m_dout_o[i] = rvalid_q[i] ? s_dout_i : '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            gnt_q    <= '0;
            last_q   <= PW'(MASTERS - 1);
            hold_q   <= '0;
            rvalid_q <= '0;
        end else begin
            gnt_q    <= gnt_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign m_gnt_o    = gnt_q;
    assign m_rvalid_o = rvalid_q;
endmodule

// File: doc/bb_arbiter.md
Name: bb_arbiter

Overview:
- N:1 Blackbone bus arbiter. It multiplexes several Blackbone masters (CPU cores, debug, DMA) onto one shared Blackbone slave port, typically the input of the slave-side address decoder.
- Round-robin, registered one-hot grant with optional hold limit.
- Returns read data to the owning master with a registered valid strobe, covering the slave's 1-cycle read latency.

Parameters:
- MASTERS, 2, number of master ports (2..16).
- DATA_WIDTH, 32, data width in bits; must be a multiple of 8.
- ADDR_WIDTH, 32, address width in bits.
- MAX_HOLD, 0, maximum consecutive granted cycles while others wait; 0 = unlimited.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset, asynchronous, active-high.
- m_addr_i  input  [MASTERS][ADDR_WIDTH]  master addresses.
- m_din_i  input  [MASTERS][DATA_WIDTH]  master write data.
- m_en_i  input  [MASTERS]  master access request/enable.
- m_we_i  input  [MASTERS]  master write enable.
- m_gnt_o  output  [MASTERS]  one-hot grant; master access is performed only in cycles with gnt high.
- m_dout_o  output  [MASTERS][DATA_WIDTH]  read data; s_dout_i when that master's rvalid is high, else 0.
- m_rvalid_o  output  [MASTERS]  read data valid, 1 cycle after a granted read.
- s_addr_o  output  ADDR_WIDTH  slave address.
- s_din_o  output  DATA_WIDTH  slave write data.
- s_en_o  output  1  slave enable.
- s_we_o  output  1  slave write enable.
- s_dout_i  input  DATA_WIDTH  slave read data, valid 1 cycle after a read enable.

Behaviour:
- Reset (async, rst_i=1):
  - gnt_q=0, m_rvalid_o=0, hold_cnt=0.
  - RR pointer last=MASTERS-1, so master 0 has top priority after reset.
  - s_en_o=0, s_we_o=0, s_addr_o=0, s_din_o=0, m_dout_o=0.
- State IDLE (gnt_q==0): if any m_en_i is high, at the next edge gnt_q <= one-hot of the first requester scanning last+1, last+2, … (modulo MASTERS). Go to OWNED, last <= winner, hold_cnt <= 0.
- Grant latency: a request raised in cycle N sees m_gnt_o high from cycle N+1. Requests are never granted in the same cycle.
- State OWNED (gnt_q[o]=1):
  - s_addr_o/s_din_o/s_we_o = master o's signals; s_en_o = m_en_i[o].
  - Ungranted masters' signals never reach the slave.
  - hold_cnt increments each cycle while m_en_i[o]=1, saturating at MAX_HOLD.
- Release: in a cycle where m_en_i[o]=0, s_en_o=0 and at the edge the grant is rearbitrated among current requesters (pointer starts after o).
  - Result: next owner from the following cycle, or IDLE if none.
  - Handoff costs exactly one idle slave cycle.
- Preemption (MAX_HOLD>0 only): if hold_cnt==MAX_HOLD-1 while m_en_i[o]=1 and any other m_en_i is high, rearbitrate at that edge excluding o.
  - o performs exactly MAX_HOLD accesses, then loses grant without the idle cycle.
  - o must hold en/addr/data stable until regranted. If o is the only requester, it keeps the grant and hold_cnt stays saturated.
- Read return: m_rvalid_o[i] <= gnt_q[i] & m_en_i[i] & ~m_we_i[i] (registered).
  - m_dout_o[i] = m_rvalid_o[i] ? s_dout_i : 0.
  - Rvalid still fires for a read in the last granted cycle, even if the grant moved.
- Writes: complete in the granted cycle; no response.
- Invariants: m_gnt_o is one-hot or zero. m_rvalid_o is one-hot or zero. s_en_o implies exactly one grant.
- Reset mid-transfer: everything clears asynchronously; any pending rvalid is dropped. After release, arbitration restarts from master 0.

Test Plan:
- Single requester: master 1 asserts en, we=0, addr=0x100 at cycle 2 -> gnt[1] at cycle 3, s_en_o=1/s_addr_o=0x100 at cycle 3; slave returns 0xDEADBEEF -> m_rvalid_o[1]=1, m_dout_o[1]=0xDEADBEEF at cycle 4; m_dout_o[0]=0.
- Simultaneous first requests after reset (MASTERS=2) -> gnt[0] first. Master 0 drops en after 3 accesses -> 1 idle slave cycle, then gnt[1].
- Round-robin, MASTERS=4, all requesting, each releasing after 1 access -> grant order 0,1,2,3,0 with one idle cycle between each.
- MAX_HOLD=4, master 0 streaming writes, master 2 requests -> master 0 gets exactly 4 s_en_o cycles, then gnt[2] on the next cycle with no idle gap; master 0 regranted after master 2 releases.
- Write then read by same master back-to-back -> s_we_o 1 then 0; m_rvalid_o only after the read, never after the write.
- rst_i asserted mid-read (between en and rvalid) -> all outputs 0 immediately, no rvalid. After release, with masters 3 and 0 requesting -> gnt[0].
